// File: rtl/mio_multi.sv
// mio_multi: memory-mapped IO block behind iob.
// Port 0 writes the GPIO register, port 2 toggles it, port 1 queues a byte
// for the 8N1 UART transmitter, port 3 sets the runtime baud divisor.
// Every request (including unmapped ports) completes with a one-cycle
// done pulse; a push into a full TX FIFO is held off until an entry frees.
//
// Handshake: a request is accepted on a rising edge where iob__mio_val is
// high and mio__iob_done is low (and, for port 1, the registered FIFO count
// is below FIFO_DEPTH). mio__iob_done is high for exactly the cycle after
// the accept edge, so iob drops val in that cycle without a re-accept.
module mio_multi #(
    parameter int GPIO_W     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 868,
    parameter int PORT_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iob__mio_val,
    input  logic [PORT_W-1:0] iob__mio_port,
    input  logic [31:0]       iob__mio_wdata,
    output logic              mio__iob_done,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              uart_txd,
    output logic              uart_fifo_full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [PORT_W-1:0] P_GPIO   = PORT_W'(0);
    localparam logic [PORT_W-1:0] P_FIFO   = PORT_W'(1);
    localparam logic [PORT_W-1:0] P_TOGGLE = PORT_W'(2);
    localparam logic [PORT_W-1:0] P_DIV    = PORT_W'(3);

    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Request side state
    logic              done_q;
    logic [GPIO_W-1:0] gpio_q;
    logic [15:0]       div_q;

    // TX FIFO state
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              full_q;

    // UART transmitter state
    uart_state_t       state_q;
    logic [7:0]        shift_q;
    logic [15:0]       bit_div_q;
    logic [15:0]       cnt_q;
    logic [2:0]        bit_idx_q;
    logic              txd_q;

    logic              req_ok;
    logic              is_push;
    logic              fifo_has_room;
    logic              accept;
    logic              push;
    logic              pop;
    logic              bit_end;
    logic [15:0]       wr_div;
    logic              unused_wdata;

    assign unused_wdata = &{1'b0, iob__mio_wdata[31:16]};

    // Accept, push and pop decisions for this cycle
    always_comb begin
        req_ok        = iob__mio_val && !done_q;
        is_push       = (iob__mio_port == P_FIFO);
        fifo_has_room = (count_q != COUNT_FULL);
        accept        = req_ok && (!is_push || fifo_has_room);
        push          = accept && is_push;
        bit_end       = (cnt_q == 16'd0);
        pop           = (count_q != '0) &&
                        ((state_q == IDLE) || ((state_q == STOP) && bit_end));
        count_d       = count_q + CW'(push) - CW'(pop);
        wr_div        = (iob__mio_wdata[15:0] == 16'd0) ? 16'd1 : iob__mio_wdata[15:0];
    end

    // Done pulse, GPIO register and baud divisor, all updated at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            gpio_q <= '0;
            div_q  <= 16'(CLK_DIV);
        end else begin
            done_q <= accept;
            if (accept) begin
                if (iob__mio_port == P_GPIO) begin
                    gpio_q <= iob__mio_wdata[GPIO_W-1:0];
                end else if (iob__mio_port == P_TOGGLE) begin
                    gpio_q <= gpio_q ^ iob__mio_wdata[GPIO_W-1:0];
                end else if (iob__mio_port == P_DIV) begin
                    div_q <= wr_div;
                end
            end
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= iob__mio_wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and registered full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == COUNT_FULL);
        end
    end

    // 8N1 transmitter: each bit lasts bit_div cycles, counted bit_div-1 down to 0.
    // The divisor is latched when a byte is popped, so mid-frame writes only
    // affect the next frame. STOP pops the next byte directly for back-to-back frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_div_q <= 16'd1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        bit_div_q <= div_q;
                        cnt_q     <= div_q - 16'd1;
                        txd_q     <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q     <= bit_div_q - 16'd1;
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= bit_div_q - 16'd1;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift_q   <= mem_q[rd_ptr_q];
                            bit_div_q <= div_q;
                            cnt_q     <= div_q - 16'd1;
                            txd_q     <= 1'b0;
                            state_q   <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mio__iob_done  = done_q;
    assign gpio_out       = gpio_q;
    assign uart_txd       = txd_q;
    assign uart_fifo_full = full_q;

endmodule
